// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and the latched
// downstream request. Widths match the default 32-bit core datapath.
// No logic here; imported by the interface and the arbiter top.
package mem_arbiter_pkg;

  localparam int unsigned ARB_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Request already formatted for the 64-bit cache port.
  typedef struct packed {
    logic                 read;
    logic                 write;
    logic [ARB_W-1:0]     address;
    logic [ARB_W/4-1:0]   be;
    logic [2*ARB_W-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, LSQ and cache-port handshake signals around the arbiter.
// Ports: i_mem_* (fetch), lsq_mem_* (load/store queue), mem_* (cache port).
// slave = arbiter view, master = requester/cache environment view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned width = ARB_W
);
  logic                 i_mem_read;
  logic [width-1:0]     i_mem_address;
  logic                 i_mem_resp;
  logic [2*width-1:0]   i_mem_rdata;

  logic                 lsq_mem_read;
  logic                 lsq_mem_write;
  logic [width-1:0]     lsq_mem_address;
  logic [width/8-1:0]   lsq_mem_byte_enable;
  logic [width-1:0]     lsq_mem_wdata;
  logic                 lsq_mem_resp;
  logic [width-1:0]     lsq_mem_rdata;

  logic                 mem_read;
  logic                 mem_write;
  logic [width-1:0]     mem_address;
  logic [width/4-1:0]   mem_byte_enable;
  logic [2*width-1:0]   mem_wdata;
  logic                 mem_resp;
  logic [2*width-1:0]   mem_rdata;

  modport slave (
    input  i_mem_read, i_mem_address,
    input  lsq_mem_read, lsq_mem_write, lsq_mem_address, lsq_mem_byte_enable, lsq_mem_wdata,
    input  mem_resp, mem_rdata,
    output i_mem_resp, i_mem_rdata, lsq_mem_resp, lsq_mem_rdata,
    output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata
  );

  modport master (
    output i_mem_read, i_mem_address,
    output lsq_mem_read, lsq_mem_write, lsq_mem_address, lsq_mem_byte_enable, lsq_mem_wdata,
    output mem_resp, mem_rdata,
    input  i_mem_resp, i_mem_rdata, lsq_mem_resp, lsq_mem_rdata,
    input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter putting fetch and LSQ requests onto one 64-bit cache port.
// Latency: request in IDLE at N drives the cache port at N+1; mem_resp returns same cycle.
// Backpressure: one transaction outstanding; requesters hold their request until *_resp.
// Ports: clk, rst (sync, active high), flush (squashes fetch data), bus (slave modport).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned width = ARB_W  // must equal ARB_W (request struct is sized by it)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_q;
  logic       last_grant_q;  // 0 = fetch granted last, 1 = LSQ granted last
  logic       squash_q;
  mem_req_t   req_q;         // doubles as the registered cache-port outputs

  logic       i_pend;
  logic       d_pend;
  mem_req_t   i_req;
  mem_req_t   d_req;

  assign i_pend = bus.i_mem_read;
  assign d_pend = bus.lsq_mem_read | bus.lsq_mem_write;

  always_comb begin
    i_req         = '0;
    i_req.read    = 1'b1;
    i_req.address = bus.i_mem_address;
    i_req.be      = '1;

    d_req         = '0;
    d_req.read    = bus.lsq_mem_read;
    d_req.write   = bus.lsq_mem_write;
    d_req.address = bus.lsq_mem_address;
    d_req.be      = {{(width/8){1'b0}}, bus.lsq_mem_byte_enable};
    d_req.wdata   = {{width{1'b0}}, bus.lsq_mem_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      squash_q     <= 1'b0;
      req_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_pend && (!d_pend || last_grant_q)) begin
            state_q      <= SERVE_I;
            req_q        <= i_req;
            last_grant_q <= 1'b0;
            squash_q     <= flush;  // a flush in the grant cycle already kills this fetch
          end else if (d_pend) begin
            state_q      <= SERVE_D;
            req_q        <= d_req;
            last_grant_q <= 1'b1;
          end
        end
        SERVE_I: begin
          if (bus.mem_resp) begin
            squash_q <= 1'b0;
            // Fetch's own request line is still high here, so only LSQ can follow directly.
            if (d_pend) begin
              state_q      <= SERVE_D;
              req_q        <= d_req;
              last_grant_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              req_q   <= '0;
            end
          end else if (flush) begin
            squash_q <= 1'b1;
          end
        end
        SERVE_D: begin
          if (bus.mem_resp) begin
            if (i_pend) begin
              state_q      <= SERVE_I;
              req_q        <= i_req;
              last_grant_q <= 1'b0;
              squash_q     <= flush;
            end else begin
              state_q <= IDLE;
              req_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= '0;
        end
      endcase
    end
  end

  // Cache port comes straight from the request register (cleared in IDLE).
  assign bus.mem_read        = req_q.read;
  assign bus.mem_write       = req_q.write;
  assign bus.mem_address     = req_q.address;
  assign bus.mem_byte_enable = req_q.be;
  assign bus.mem_wdata       = req_q.wdata;

  // Squashed fetches still complete downstream; only the response is suppressed.
  assign bus.i_mem_resp    = (state_q == SERVE_I) & bus.mem_resp & ~squash_q & ~flush;
  assign bus.lsq_mem_resp  = (state_q == SERVE_D) & bus.mem_resp;
  assign bus.i_mem_rdata   = bus.i_mem_resp ? bus.mem_rdata : '0;
  assign bus.lsq_mem_rdata = bus.lsq_mem_resp ? bus.mem_rdata[width-1:0] : '0;

endmodule
